fifo_read_ctrl: RTL and testbench
=================================

// Module: fifo_read_ctrl
// PURPOSE
//  Read-side engine for the FIFO block: drives the FIFO's active-low read strobe (FOutN)
//  and clear strobe (FClrN) from the FIFO's registered empty flag.
//  Moves each popped word into a 2-entry output buffer.
//  Presents the words downstream on a valid/ready handshake with burst framing (Out_Last).
//  Sits between FIFO.F_Data/F_EmptyN and any consumer that must not see FIFO timing.
// PARAMETERS
//  FWIDTH     32  data word width; must match the FIFO width
//  BURST_LEN  4   words per burst; Out_Last marks the final word; legal range >= 1
//  CNT_WIDTH  16  width of the Word_Cnt transfer counter
// PORTS
//  Clk        in   1          single clock, all logic on posedge
//  RstN       in   1          asynchronous, active-low reset
//  Enable     in   1          1 = allow popping from the FIFO
//  ClrReq     in   1          1-cycle request to flush the FIFO and this block
//  F_Data     in   FWIDTH     FIFO read data (combinational from FIFO read pointer)
//  F_EmptyN   in   1          FIFO not-empty flag (registered in FIFO, 0 = empty)
//  FOutN      out  1          FIFO read strobe, active low
//  FClrN      out  1          FIFO synchronous clear, active low
//  Out_Data   out  FWIDTH     downstream data = buffer head entry
//  Out_Valid  out  1          downstream valid
//  Out_Ready  in   1          downstream ready
//  Out_Last   out  1          current Out_Data is the last word of a burst
//  Word_Cnt   out  CNT_WIDTH  total downstream transfers since reset or clear, wraps
//  Busy       out  1          state != IDLE or buffer occupancy != 0
// BEHAVIOUR
//  Reset values:
//   - state=IDLE, occ=0, beat_cnt=0, Word_Cnt=0
//   - FOutN=1, FClrN=1, Out_Valid=0, Out_Last=0, Busy=0
//  FSM (registered):
//   - IDLE -> RUN when Enable=1
//   - RUN -> IDLE when Enable=0
//   - any state -> CLEAR when ClrReq=1; ClrReq beats Enable
//   - CLEAR lasts exactly 1 cycle, then -> RUN if Enable=1, else IDLE
//  Pop:
//   - pop = (state==RUN) & F_EmptyN & (occ<2)
//   - FOutN = ~pop; no combinational path from Out_Ready to FOutN
//   - Enable change affects FOutN one cycle later (via state)
//   - on a pop cycle, F_Data is written into the buffer at that clock edge
//   - FIFO flags are valid again next cycle, so back-to-back pops are legal
//   - never pop when F_EmptyN=0
//  Buffer:
//   - 2-entry FIFO-ordered buffer; occ in 0..2
//   - Out_Valid = (occ!=0)
//   - xfer = Out_Valid & Out_Ready
//   - pop and xfer in the same cycle: occ unchanged, data order preserved
//   - sustained rate is 1 word/cycle with occ steady at 1
//   - Out_Data/Out_Valid hold stable while Out_Valid=1 & Out_Ready=0
//     (exception: CLEAR, see below)
//   - in IDLE the buffer keeps draining downstream; no new pops
//  Framing:
//   - beat_cnt (ceil(log2(BURST_LEN)) bits) increments on xfer
//   - beat_cnt wraps to 0 after BURST_LEN-1
//   - Out_Last = Out_Valid & (beat_cnt==BURST_LEN-1)
//   - BURST_LEN=1: Out_Last = Out_Valid
//  Word_Cnt: +1 per xfer, modulo 2^CNT_WIDTH (0xFFFF -> 0 at default width).
//  CLEAR cycle:
//   - FClrN=0 and FOutN=1, both for exactly that cycle
//   - Out_Valid forced to 0 that cycle; any xfer is ignored
//   - at the end of the cycle: occ=0, beat_cnt=0, Word_Cnt=0
//   - buffered data is discarded; dropping Out_Valid here is the defined flush semantics
//  RstN asserted mid-burst: everything returns to reset values immediately (async).
// STRUCTURE
//  - Shared package/include: FWIDTH/FDEPTH defines (already used by the FIFO block) and the
//    FSM state encoding: IDLE=2'd0, RUN=2'd1, CLEAR=2'd2.
//  - One sub-module, fifo_read_skid: the 2-entry buffer
//    (push/data_in, pop/data_out, occ, flush).
//  - The top level holds the FSM, strobes, beat_cnt and Word_Cnt.
// TESTING (bench instantiates FIFO with FDEPTH=4 plus this block)
//  - Write 0xA0..0xA3, Enable=1, Out_Ready=1
//    -> FOutN low 4 consecutive cycles; Out_Data A0,A1,A2,A3 on consecutive cycles;
//       Out_Last only with A3; Word_Cnt=4.
//  - Out_Ready=0 with 4 words stored -> exactly 2 pops, then FOutN=1; occ=2;
//    Out_Data=A0 held stable. Raise Out_Ready -> remaining words in order, no loss or duplicate.
//  - FIFO empty, Enable=1 -> FOutN stays 1. Write 0x55
//    -> pop in the cycle after F_EmptyN rises; Out_Data=0x55; no second pop.
//  - ClrReq during a stream with occ=2 -> FClrN=0 for exactly 1 cycle; Out_Valid=0 that cycle;
//    Word_Cnt=0, beat_cnt=0; FIFO F_EmptyN=0 afterwards.
//  - Enable dropped mid-stream -> at most 1 further pop; buffer drains; Busy falls to 0 once occ=0.
//  - Preload Word_Cnt to 0xFFFE via 0xFFFE transfers (or force), then 2 more xfers
//    -> Word_Cnt=0x0000. Assert RstN low mid-burst -> all outputs at reset values.

Source files
------------

// File: rtl/fifo_read_ctrl_pkg.sv
// Shared constants for the FIFO read-side engine.
// Word width/depth of the FIFO block and the read FSM encoding.
package fifo_read_ctrl_pkg;

    localparam int FIFO_WIDTH = 32;
    localparam int FIFO_DEPTH = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

endpackage

// File: rtl/fifo_read_skid.sv
// Two-entry in-order buffer between FIFO pops and the downstream port.
// Head entry is always r_d0; flush empties it in one cycle.
module fifo_read_skid #(
    parameter int W = 32
) (
    input  logic         Clk,
    input  logic         RstN,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    input  logic         i_flush,
    output logic [W-1:0] o_data,
    output logic [1:0]   o_occ
);

    logic [W-1:0] r_d0;
    logic [W-1:0] r_d1;
    logic [1:0]   r_occ;

    // Storage and occupancy update; simultaneous push/pop keeps order
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            r_d0  <= '0;
            r_d1  <= '0;
            r_occ <= 2'd0;
        end else if (i_flush) begin
            r_occ <= 2'd0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_occ == 2'd0) r_d0 <= i_data;
                    else               r_d1 <= i_data;
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_d0  <= r_d1;
                    r_occ <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_d0 <= i_data;
                    end else begin
                        r_d0 <= r_d1;
                        r_d1 <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_data = r_d0;
    assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_read_ctrl.sv
// FIFO read engine: pops the FIFO into a 2-entry buffer and
// presents words on a valid/ready port with burst framing.
module fifo_read_ctrl
    import fifo_read_ctrl_pkg::*;
#(
    parameter int FWIDTH    = FIFO_WIDTH,
    parameter int BURST_LEN = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 Clk,
    input  logic                 RstN,
    input  logic                 Enable,
    input  logic                 ClrReq,
    input  logic [FWIDTH-1:0]    F_Data,
    input  logic                 F_EmptyN,
    output logic                 FOutN,
    output logic                 FClrN,
    output logic [FWIDTH-1:0]    Out_Data,
    output logic                 Out_Valid,
    input  logic                 Out_Ready,
    output logic                 Out_Last,
    output logic [CNT_WIDTH-1:0] Word_Cnt,
    output logic                 Busy
);

    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

    logic [1:0]           r_state;
    logic [1:0]           w_next;
    logic [BW-1:0]        r_beat;
    logic [CNT_WIDTH-1:0] r_word_cnt;
    logic [1:0]           w_occ;
    logic [FWIDTH-1:0]    w_head;
    logic                 w_clear;
    logic                 w_pop;
    logic                 w_valid;
    logic                 w_xfer;

    assign w_clear = (r_state == ST_CLEAR);
    assign w_pop   = (r_state == ST_RUN) & F_EmptyN & (w_occ != 2'd2);
    assign w_valid = (w_occ != 2'd0) & ~w_clear;
    assign w_xfer  = w_valid & Out_Ready;

    // Next state: a clear request overrides everything else
    always_comb begin
        w_next = r_state;
        if (ClrReq) begin
            w_next = ST_CLEAR;
        end else begin
            case (r_state)
                ST_IDLE:  if (Enable) w_next = ST_RUN;
                ST_RUN:   if (!Enable) w_next = ST_IDLE;
                ST_CLEAR: w_next = Enable ? ST_RUN : ST_IDLE;
                default:  w_next = ST_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Burst beat position, advanced on each downstream transfer
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            r_beat <= '0;
        end else if (w_clear) begin
            r_beat <= '0;
        end else if (w_xfer) begin
            if (r_beat == LAST_BEAT) r_beat <= '0;
            else                     r_beat <= r_beat + BW'(1);
        end
    end

    // Running transfer count, wraps naturally at full width
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            r_word_cnt <= '0;
        end else if (w_clear) begin
            r_word_cnt <= '0;
        end else if (w_xfer) begin
            r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
        end
    end

    fifo_read_skid #(
        .W (FWIDTH)
    ) u_skid (
        .Clk     (Clk),
        .RstN    (RstN),
        .i_push  (w_pop),
        .i_data  (F_Data),
        .i_pop   (w_xfer),
        .i_flush (w_clear),
        .o_data  (w_head),
        .o_occ   (w_occ)
    );

    assign FOutN     = ~w_pop;
    assign FClrN     = ~w_clear;
    assign Out_Data  = w_head;
    assign Out_Valid = w_valid;
    assign Out_Last  = w_valid & (r_beat == LAST_BEAT);
    assign Word_Cnt  = r_word_cnt;
    assign Busy      = (r_state != ST_IDLE) | (w_occ != 2'd0);

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl: a depth-4 FIFO model feeds the DUT,
// a scoreboard queue holds written words in expected output order.
module tb_fifo_read_ctrl;

    localparam int FW = 32;
    localparam int BL = 4;
    localparam int CW = 8;

    logic          Clk = 1'b0;
    logic          RstN;
    logic          Enable;
    logic          ClrReq;
    logic [FW-1:0] F_Data;
    logic          F_EmptyN;
    logic          FOutN;
    logic          FClrN;
    logic [FW-1:0] Out_Data;
    logic          Out_Valid;
    logic          Out_Ready;
    logic          Out_Last;
    logic [CW-1:0] Word_Cnt;
    logic          Busy;

    logic          wr_en;
    logic [FW-1:0] wr_data;

    logic [FW-1:0] fmem [4];
    int fcnt, wptr, rptr, fn;

    logic [FW-1:0] exp_q [$];
    int beat_m, wc_m;
    bit hold_v;
    logic [FW-1:0] hold_d;
    int pops, run, maxrun, clr_cycles;
    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    fifo_read_ctrl #(
        .FWIDTH    (FW),
        .BURST_LEN (BL),
        .CNT_WIDTH (CW)
    ) dut (
        .Clk       (Clk),
        .RstN      (RstN),
        .Enable    (Enable),
        .ClrReq    (ClrReq),
        .F_Data    (F_Data),
        .F_EmptyN  (F_EmptyN),
        .FOutN     (FOutN),
        .FClrN     (FClrN),
        .Out_Data  (Out_Data),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Out_Last  (Out_Last),
        .Word_Cnt  (Word_Cnt),
        .Busy      (Busy)
    );

    task automatic chk(input bit ok, input string nm,
                       input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // FIFO model: registered empty flag, combinational read data
    assign F_Data = fmem[rptr[1:0]];
    always @(posedge Clk or negedge RstN) begin
        if (!RstN || !FClrN) begin
            fcnt <= 0; wptr <= 0; rptr <= 0; F_EmptyN <= 1'b0;
        end else begin
            fn = fcnt;
            if (!FOutN && fcnt > 0) begin
                rptr <= (rptr + 1) % 4; fn--;
            end
            if (wr_en && fcnt < 4) begin
                fmem[wptr] <= wr_data; wptr <= (wptr + 1) % 4; fn++;
            end
            fcnt <= fn;
            F_EmptyN <= (fn != 0);
        end
    end

    // Monitor / scoreboard
    always @(negedge Clk) begin
        if (RstN) begin
            if (!FOutN) begin
                pops++; run++;
                if (run > maxrun) maxrun = run;
                chk(F_EmptyN, "pop_when_empty", 0, 1);
            end else begin
                run = 0;
            end
            if (!FClrN) begin
                clr_cycles++;
                chk(!Out_Valid, "clr_valid", Out_Valid, 0);
                chk(FOutN, "clr_foutn", FOutN, 1);
                exp_q.delete();
                beat_m = 0; wc_m = 0; hold_v = 0;
            end else begin
                if (hold_v)
                    chk(Out_Valid && Out_Data == hold_d, "hold",
                        Out_Data, hold_d);
                if (Out_Valid) begin
                    if (exp_q.size() == 0) begin
                        chk(0, "unexpected_word", Out_Data, 0);
                    end else begin
                        chk(Out_Data == exp_q[0], "data", Out_Data, exp_q[0]);
                        chk(Out_Last == (beat_m == BL - 1), "last",
                            Out_Last, (beat_m == BL - 1));
                        chk(Word_Cnt == CW'(wc_m), "word_cnt", Word_Cnt, wc_m);
                        if (Out_Ready) begin
                            void'(exp_q.pop_front());
                            beat_m = (beat_m + 1) % BL;
                            wc_m = (wc_m + 1) % (1 << CW);
                        end
                    end
                end
                hold_v = Out_Valid && !Out_Ready;
                hold_d = Out_Data;
            end
        end
    end

    task automatic step();
        @(posedge Clk); #1;
        wr_en = 1'b0; ClrReq = 1'b0;
    endtask

    task automatic put(input logic [FW-1:0] d, output bit ok);
        ok = (fcnt < 4) && FClrN;
        if (ok) begin
            wr_en = 1'b1; wr_data = d; exp_q.push_back(d);
        end
    endtask

    task automatic drain(input int lim, input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < lim) begin step(); n++; end
        chk(exp_q.size() == 0, nm, exp_q.size(), 0);
    endtask

    task automatic chk_reset(input string nm);
        chk(FOutN == 1'b1, {nm, "_foutn"}, FOutN, 1);
        chk(FClrN == 1'b1, {nm, "_fclrn"}, FClrN, 1);
        chk(Out_Valid == 1'b0, {nm, "_valid"}, Out_Valid, 0);
        chk(Out_Last == 1'b0, {nm, "_last"}, Out_Last, 0);
        chk(Busy == 1'b0, {nm, "_busy"}, Busy, 0);
        chk(Word_Cnt == '0, {nm, "_wcnt"}, Word_Cnt, 0);
    endtask

    initial begin
        bit ok;
        int sent;
        RstN = 1'b0; Enable = 1'b0; ClrReq = 1'b0;
        Out_Ready = 1'b0; wr_en = 1'b0; wr_data = '0;
        beat_m = 0; wc_m = 0; hold_v = 0;
        pops = 0; run = 0; maxrun = 0; clr_cycles = 0;
        repeat (2) @(posedge Clk);
        #1;
        chk_reset("reset");
        RstN = 1'b1;
        step();

        // Four words, streaming at full rate
        for (int i = 0; i < 4; i++) begin put(32'hA0 + i, ok); step(); end
        step();
        pops = 0; maxrun = 0;
        Enable = 1'b1; Out_Ready = 1'b1;
        repeat (10) step();
        chk(pops == 4, "burst_pops", pops, 4);
        chk(maxrun == 4, "burst_consecutive", maxrun, 4);
        chk(Word_Cnt == 4, "burst_wcnt", Word_Cnt, 4);

        // Backpressure: buffer fills to two and holds head
        Enable = 1'b0; Out_Ready = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin put(32'hB0 + i, ok); step(); end
        step();
        pops = 0;
        Enable = 1'b1;
        repeat (8) step();
        chk(pops == 2, "bp_pops", pops, 2);
        chk(FOutN == 1'b1, "bp_foutn", FOutN, 1);
        chk(Out_Valid && Out_Data == 32'hB0, "bp_head", Out_Data, 32'hB0);
        Out_Ready = 1'b1;
        drain(20, "bp_drain");

        // Empty FIFO, then a single word
        repeat (3) step();
        pops = 0;
        repeat (5) step();
        chk(pops == 0, "empty_no_pop", pops, 0);
        put(32'h55, ok); step();
        repeat (5) step();
        chk(pops == 1, "single_pop", pops, 1);
        chk(exp_q.size() == 0, "single_out", exp_q.size(), 0);

        // Clear with two buffered words
        Enable = 1'b0; Out_Ready = 1'b0;
        for (int i = 0; i < 4; i++) begin put(32'hC0 + i, ok); step(); end
        step();
        Enable = 1'b1;
        repeat (4) step();
        clr_cycles = 0;
        Out_Ready = 1'b1; ClrReq = 1'b1;
        step();
        repeat (4) step();
        chk(clr_cycles == 1, "clr_len", clr_cycles, 1);
        chk(Word_Cnt == '0, "clr_wcnt", Word_Cnt, 0);
        chk(F_EmptyN == 1'b0, "clr_fifo_empty", F_EmptyN, 0);
        chk(Out_Valid == 1'b0, "clr_flushed", Out_Valid, 0);

        // Enable dropped mid-stream
        Out_Ready = 1'b1;
        for (int i = 0; i < 4; i++) begin put(32'hD0 + i, ok); step(); end
        pops = 0;
        Enable = 1'b0;
        repeat (6) step();
        chk(pops <= 1, "dis_pops", pops, 1);
        chk(Busy == 1'b0, "dis_busy", Busy, 0);
        chk(Out_Valid == 1'b0, "dis_valid", Out_Valid, 0);
        Enable = 1'b1;
        drain(20, "dis_drain");

        // Randomized traffic with occasional clears
        for (int c = 0; c < 600; c++) begin
            Enable = ($urandom_range(0, 9) != 0);
            Out_Ready = $urandom_range(0, 1);
            if ($urandom_range(0, 9) < 7) put($urandom, ok);
            if ($urandom_range(0, 59) == 0) ClrReq = 1'b1;
            step();
        end
        Enable = 1'b1; Out_Ready = 1'b1;
        drain(40, "rand_drain");

        // Word counter wrap
        ClrReq = 1'b1; step(); step();
        sent = 0;
        for (int c = 0; c < 2000 && sent < 254; c++) begin
            put(32'h1000 + sent, ok);
            if (ok) sent++;
            step();
        end
        drain(20, "wrap_drain1");
        chk(Word_Cnt == 8'hFE, "wrap_pre", Word_Cnt, 8'hFE);
        for (int i = 0; i < 2; i++) begin put(32'hE0 + i, ok); step(); end
        drain(20, "wrap_drain2");
        chk(Word_Cnt == 8'h00, "wrap_post", Word_Cnt, 0);

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < 3; i++) begin put(32'hF0 + i, ok); step(); end
        @(posedge Clk); #3;
        RstN = 1'b0;
        #1;
        chk_reset("midreset");
        wr_en = 1'b0;
        exp_q.delete(); beat_m = 0; wc_m = 0; hold_v = 0;
        #13;
        RstN = 1'b1;
        Enable = 1'b0;
        step(); step();
        chk(Out_Valid == 1'b0, "post_reset_valid", Out_Valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
